// File: rtl/led_marquee_scroller.sv
// Scrolling marquee: a runtime-loadable message buffer is shifted one character per prescaler tick into a display register.
// Optional blink output gating is enabled by defining MARQUEE_BLINK_EN.
module led_marquee_scroller #(
   parameter int SEG_W      = 16,
   parameter int NUM_DIGITS = 4,
   parameter int DEPTH      = 32,
   parameter int ADDR_W     = 5,
   parameter int TICK_DIV   = 8388608
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        run,
   input  logic                        dir,
   input  logic [ADDR_W-1:0]           msg_last,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [SEG_W-1:0]            wr_data,
`ifdef MARQUEE_BLINK_EN
   input  logic                        blink,
`endif
   output logic [NUM_DIGITS*SEG_W-1:0] seg_out,
   output logic                        step_pulse,
   output logic                        wrap
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   LAST_MAX = (ADDR_W + 1)'(DEPTH - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [SEG_W-1:0]  disp_q [NUM_DIGITS];
   logic [SEG_W-1:0]  disp_d [NUM_DIGITS];
   logic [SEG_W-1:0]  msg_buf_q [DEPTH];
   logic [SEG_W-1:0]  msg_buf_d [DEPTH];
   logic              step_pulse_q, step_pulse_d;
   logic              wrap_q, wrap_d;

   logic                        tick;
   logic                        shift;
   logic [ADDR_W:0]             last_eff;
   logic                        ptr_wrap;
   logic [SEG_W-1:0]            char_c;
   logic [NUM_DIGITS*SEG_W-1:0] disp_flat;

   always_comb begin
      tick     = (cnt_q == CNT_MAX);
      shift    = tick & run;
      cnt_d    = tick ? '0 : cnt_q + 1'b1;

      // A msg_last beyond the buffer clamps to the final entry; >= also
      // recovers when msg_last is lowered below the current pointer.
      last_eff = ({1'b0, msg_last} >= DEPTH_X) ? LAST_MAX : {1'b0, msg_last};
      ptr_wrap = ({1'b0, ptr_q} >= last_eff);
      char_c   = msg_buf_q[ptr_q];

      ptr_d        = ptr_q;
      step_pulse_d = 1'b0;
      wrap_d       = 1'b0;
      disp_d       = disp_q;
      if (shift) begin
         ptr_d        = ptr_wrap ? '0 : ptr_q + 1'b1;
         step_pulse_d = 1'b1;
         wrap_d       = ptr_wrap;
         if (!dir) begin
            for (int unsigned k = 0; k < NUM_DIGITS - 1; k++)
               disp_d[k] = disp_q[k+1];
            disp_d[NUM_DIGITS-1] = char_c;
         end else begin
            for (int unsigned k = 1; k < NUM_DIGITS; k++)
               disp_d[k] = disp_q[k-1];
            disp_d[0] = char_c;
         end
      end

      // The shift above reads msg_buf_q, so a same-cycle write is seen next pass.
      msg_buf_d = msg_buf_q;
      if (wr_en && ({1'b0, wr_addr} < DEPTH_X))
         msg_buf_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         ptr_q        <= '0;
         step_pulse_q <= 1'b0;
         wrap_q       <= 1'b0;
         for (int unsigned k = 0; k < NUM_DIGITS; k++)
            disp_q[k] <= '1;
         for (int unsigned a = 0; a < DEPTH; a++)
            msg_buf_q[a] <= '1;
      end else begin
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         step_pulse_q <= step_pulse_d;
         wrap_q       <= wrap_d;
         disp_q       <= disp_d;
         msg_buf_q    <= msg_buf_d;
      end
   end

   always_comb begin
      disp_flat = '1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++)
         disp_flat[k*SEG_W +: SEG_W] = disp_q[k];
   end

`ifdef MARQUEE_BLINK_EN
   logic phase_q, phase_d;

   always_comb begin
      phase_d = tick ? ~phase_q : phase_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) phase_q <= 1'b0;
      else     phase_q <= phase_d;
   end

   assign seg_out = (blink && phase_q) ? '1 : disp_flat;
`else
   assign seg_out = disp_flat;
`endif

   assign step_pulse = step_pulse_q;
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_led_marquee_scroller.sv
// Bench for led_marquee_scroller: queue-based reference model plus directed scenarios with literal expectations.
module tb_led_marquee_scroller;

   localparam int SEG_W      = 16;
   localparam int NUM_DIGITS = 4;
   localparam int DEPTH      = 8;
   localparam int ADDR_W     = 3;
   localparam int TICK_DIV   = 4;
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic                        run = 1'b0;
   logic                        dir = 1'b0;
   logic [ADDR_W-1:0]           msg_last = '0;
   logic                        wr_en = 1'b0;
   logic [ADDR_W-1:0]           wr_addr = '0;
   logic [SEG_W-1:0]            wr_data = '0;
`ifdef MARQUEE_BLINK_EN
   logic                        blink = 1'b0;
`endif
   logic [NUM_DIGITS*SEG_W-1:0] seg_out;
   logic                        step_pulse;
   logic                        wrap;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   led_marquee_scroller #(
      .SEG_W(SEG_W), .NUM_DIGITS(NUM_DIGITS), .DEPTH(DEPTH),
      .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .dir(dir), .msg_last(msg_last),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MARQUEE_BLINK_EN
      .blink(blink),
`endif
      .seg_out(seg_out), .step_pulse(step_pulse), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: display as a queue of characters, tick derived from edge count.
   int          edges;
   logic [15:0] mbuf [DEPTH];
   logic [15:0] disp [$];
   int          ptr;
   bit          exp_step, exp_wrap;

   always @(posedge clk or posedge rst) begin
      logic [15:0] c;
      int last;
      if (rst) begin
         edges = 0; ptr = 0; exp_step = 0; exp_wrap = 0;
         disp.delete();
         repeat (NUM_DIGITS) disp.push_back(16'hFFFF);
         foreach (mbuf[i]) mbuf[i] = 16'hFFFF;
      end else begin
         edges++;
         exp_step = 0; exp_wrap = 0;
         if ((edges % TICK_DIV) == 0 && run) begin
            c = mbuf[ptr];
            if (!dir) begin disp.push_back(c);  void'(disp.pop_front()); end
            else      begin disp.push_front(c); void'(disp.pop_back());  end
            last = (int'(msg_last) >= DEPTH) ? DEPTH - 1 : int'(msg_last);
            ptr = (ptr >= last) ? 0 : ptr + 1;
            exp_step = 1;
            exp_wrap = (ptr == 0);
         end
         if (wr_en && int'(wr_addr) < DEPTH) mbuf[wr_addr] = wr_data;
      end
   end

   function automatic logic [63:0] model_seg();
      logic [63:0] v;
      for (int k = 0; k < NUM_DIGITS; k++) v[k*16 +: 16] = disp[k];
`ifdef MARQUEE_BLINK_EN
      if (blink && ((edges / TICK_DIV) % 2 == 1)) v = ALL1;
`endif
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_seg_out", seg_out, model_seg());
         chk("model_step_pulse", 64'(step_pulse), 64'(exp_step));
         chk("model_wrap", 64'(wrap), 64'(exp_wrap));
      end
   end

   // Advance to the falling edge following rising edge e (since reset), then settle 1 time unit.
   task automatic goto(input int e);
      int guard = 0;
      while (edges < e && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (edges < e) begin
         errors++;
         $display("FAIL goto_timeout: reached %0d wanted %0d", edges, e);
      end
      #1;
   endtask

   task automatic load_msg();
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0001;
      goto(1); wr_addr = 3'd1; wr_data = 16'h0002;
      goto(2); wr_addr = 3'd2; wr_data = 16'h0003;
      goto(3); wr_en = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b1;
      #1 chk_en = 1'b1;
      chk("reset_seg", seg_out, ALL1);
      @(negedge clk); @(negedge clk); #1;
      chk("reset_step", 64'(step_pulse), 64'd0);
      chk("reset_wrap", 64'(wrap), 64'd0);

      // Left scroll and wrap
      rst = 1'b0; run = 1'b1; dir = 1'b0; msg_last = 3'd2;
      load_msg();
      goto(12);
      chk("left_3ticks", seg_out, 64'h0003_0002_0001_FFFF);
      chk("left_wrap", 64'(wrap), 64'd1);
      goto(16);
      chk("left_4th", seg_out, 64'h0001_0003_0002_0001);
      chk("left_nowrap", 64'(wrap), 64'd0);

      // Asynchronous reset mid-step
      goto(17);
      #2 rst = 1'b1;
      #1 chk("midrst_seg", seg_out, ALL1);
      chk("midrst_step", 64'(step_pulse), 64'd0);
      chk("midrst_wrap", 64'(wrap), 64'd0);
      @(negedge clk); @(negedge clk); #1;
      rst = 1'b0; dir = 1'b1; msg_last = 3'd2; run = 1'b1;
      load_msg();
      chk("first_shift_not_yet", 64'(step_pulse), 64'd0);
      chk("blank_before_first", seg_out, ALL1);
      goto(4);
      chk("first_shift_edge4", 64'(step_pulse), 64'd1);
      chk("right_1tick", seg_out, 64'hFFFF_FFFF_FFFF_0001);
      goto(8);
      chk("right_2ticks", seg_out, 64'hFFFF_FFFF_0001_0002);

      // Pause for ten ticks, resume mid-period
      run = 1'b0;
      goto(49);
      chk("pause_hold", seg_out, 64'hFFFF_FFFF_0001_0002);
      goto(50);
      run = 1'b1;
      goto(51);
      chk("resume_wait", 64'(step_pulse), 64'd0);
      goto(52);
      chk("resume_step", 64'(step_pulse), 64'd1);
      chk("resume_seg", seg_out, 64'hFFFF_0001_0002_0003);
      chk("resume_wrap", 64'(wrap), 64'd1);

      // Write collision then shrinking msg_last below ptr
      goto(59);
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h00AA;
      goto(60);
      wr_en = 1'b0;
      chk("collision_old", seg_out, 64'h0002_0003_0001_0002);
      msg_last = 3'd1;
      goto(64);
      chk("shrink_seg", seg_out, 64'h0003_0001_0002_0003);
      chk("shrink_wrap", 64'(wrap), 64'd1);
      goto(72);
      chk("collision_new", 64'(seg_out[15:0]), 64'h00AA);

      // Single-character message repeats buf[0]
      msg_last = 3'd0;
      goto(80);
      chk("repeat_buf0", 64'(seg_out[31:0]), 64'h0001_0001);

      // Direction change without reordering
      dir = 1'b0;
`ifdef MARQUEE_BLINK_EN
      blink = 1'b1;
`endif
      goto(96);
`ifdef MARQUEE_BLINK_EN
      blink = 1'b0;
`endif
      goto(104);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
